// File: rtl/sqrt_mantissa_core.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_mantissa_core
// Brief    : Iterative modified non-restoring significand square root, one
//            root bit per clock. Optional macro SQRT_EARLY_EXIT_EN ends exact
//            roots as soon as the remainder and unconsumed radicand are zero.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_mantissa_core #(
    parameter int DOUBLE_ROOT_BITS = 53,
    parameter int SINGLE_ROOT_BITS = 24,
    parameter int BINARY_SIZE      = 2 * DOUBLE_ROOT_BITS,
    parameter int REM_SIZE         = DOUBLE_ROOT_BITS + 2
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          start,
    input  logic                          isFloat,
    input  logic                          isExponentOdd,
    input  logic [DOUBLE_ROOT_BITS-2:0]   fraction,
    output logic                          busy,
    output logic                          done,
    output logic [DOUBLE_ROOT_BITS-1:0]   root,
    output logic                          isExact
);

    localparam int c_CNT_W = $clog2(DOUBLE_ROOT_BITS + 1);
    localparam int c_PAD_W = BINARY_SIZE - 2 * SINGLE_ROOT_BITS;
    localparam logic [c_CNT_W-1:0] c_N_SINGLE = c_CNT_W'(SINGLE_ROOT_BITS);
    localparam logic [c_CNT_W-1:0] c_N_DOUBLE = c_CNT_W'(DOUBLE_ROOT_BITS);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [BINARY_SIZE-1:0]         r_rad;
    logic [BINARY_SIZE-1:0]         w_rad_init;
    logic [BINARY_SIZE-1:0]         w_rad_next;
    logic signed [REM_SIZE-1:0]     r_rem;
    logic signed [REM_SIZE-1:0]     w_rem4;
    logic signed [REM_SIZE-1:0]     w_rem_next;
    logic signed [REM_SIZE-1:0]     w_rem_corr;
    logic [DOUBLE_ROOT_BITS-1:0]    r_q;
    logic [DOUBLE_ROOT_BITS-1:0]    w_q_next;
    logic [DOUBLE_ROOT_BITS-1:0]    w_root_final;
    logic [DOUBLE_ROOT_BITS-1:0]    r_root;
    logic [c_CNT_W-1:0]             r_cnt;
    logic [c_CNT_W-1:0]             w_steps;
    logic [SINGLE_ROOT_BITS-2:0]    w_sfrac;
    logic                           r_isfloat;
    logic                           r_exact;
    logic                           w_last;
    logic                           w_finish;
    logic                           w_exact;

    // Radicand is left-aligned so both precisions consume bits from the top.
    always_comb begin
        w_sfrac    = fraction[SINGLE_ROOT_BITS-2:0];
        w_rad_init = '0;
        if (isFloat) begin
            if (isExponentOdd)
                w_rad_init = {1'b1, w_sfrac, {SINGLE_ROOT_BITS{1'b0}}, {c_PAD_W{1'b0}}};
            else
                w_rad_init = {2'b01, w_sfrac, {(SINGLE_ROOT_BITS-1){1'b0}}, {c_PAD_W{1'b0}}};
        end else begin
            if (isExponentOdd)
                w_rad_init = {1'b1, fraction, {DOUBLE_ROOT_BITS{1'b0}}};
            else
                w_rad_init = {2'b01, fraction, {(DOUBLE_ROOT_BITS-1){1'b0}}};
        end
    end

    assign w_rem4     = (r_rem <<< 2) + $signed({{(REM_SIZE-2){1'b0}}, r_rad[BINARY_SIZE-1 -: 2]});
    assign w_rem_next = r_rem[REM_SIZE-1] ? (w_rem4 + $signed({r_q, 2'b11}))
                                          : (w_rem4 - $signed({r_q, 2'b01}));
    assign w_q_next   = {r_q[DOUBLE_ROOT_BITS-2:0], ~w_rem_next[REM_SIZE-1]};
    // A negative final remainder is exact when adding back 2q+1 gives zero.
    assign w_rem_corr = w_rem_next + $signed({1'b0, w_q_next, 1'b1});
    assign w_exact    = (w_rem_next == '0) || (w_rem_next[REM_SIZE-1] && (w_rem_corr == '0));
    assign w_rad_next = {r_rad[BINARY_SIZE-3:0], 2'b00};
    assign w_steps    = r_isfloat ? c_N_SINGLE : c_N_DOUBLE;
    assign w_last     = (r_cnt == (w_steps - c_ONE));

`ifdef SQRT_EARLY_EXIT_EN
    logic [c_CNT_W-1:0] w_remaining;
    logic               w_exit;
    assign w_remaining  = w_steps - r_cnt - c_ONE;
    assign w_exit       = (w_rem_next == '0) && (w_rad_next == '0);
    assign w_finish     = w_last || w_exit;
    assign w_root_final = w_q_next << w_remaining;
`else
    assign w_finish     = w_last;
    assign w_root_final = w_q_next;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_finish) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rad     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_isfloat <= 1'b0;
            r_root    <= '0;
            r_exact   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rad     <= w_rad_init;
                        r_rem     <= '0;
                        r_q       <= '0;
                        r_cnt     <= '0;
                        r_isfloat <= isFloat;
                        r_root    <= '0;
                        r_exact   <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_rad <= w_rad_next;
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + c_ONE;
                    if (w_finish) begin
                        r_root  <= w_root_final;
                        r_exact <= w_exact;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign root    = r_root;
    assign isExact = r_exact;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_mantissa_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_mantissa_core
// Brief    : Directed-vector and reference-model bench for sqrt_mantissa_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_mantissa_core;

    typedef struct {
        logic        isf;
        logic        odd;
        logic [51:0] frac;
        logic [52:0] exp_root;
        logic        exp_exact;
        int          lat;
        int          lat_ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        isFloat;
    logic        isExponentOdd;
    logic [51:0] fraction;
    logic        busy;
    logic        done;
    logic [52:0] root;
    logic        isExact;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sqrt_mantissa_core dut (
        .clk           (clk),
        .rstN          (rstN),
        .start         (start),
        .isFloat       (isFloat),
        .isExponentOdd (isExponentOdd),
        .fraction      (fraction),
        .busy          (busy),
        .done          (done),
        .root          (root),
        .isExact       (isExact)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Integer floor(sqrt(R)) by trial squaring, independent of the DUT algorithm.
    function automatic void ref_sqrt(input logic f, input logic o, input logic [51:0] fr,
                                     output logic [52:0] q, output logic ex);
        logic [105:0] rad;
        logic [105:0] t;
        logic [105:0] c;
        logic [105:0] sq;
        int           nb;
        if (f) begin
            rad = {82'd0, 1'b1, fr[22:0]};
            rad = rad << (o ? 24 : 23);
            nb  = 24;
        end else begin
            rad = {53'd0, 1'b1, fr};
            rad = rad << (o ? 53 : 52);
            nb  = 53;
        end
        t = '0;
        for (int b = nb - 1; b >= 0; b--) begin
            c  = t | (106'd1 << b);
            sq = c * c;
            if (sq <= rad) t = c;
        end
        q  = t[52:0];
        sq = t * t;
        ex = (sq == rad);
    endfunction

    task automatic run_job(input logic f, input logic o, input logic [51:0] fr,
                           output logic [52:0] r_out, output logic x_out, output int lat);
        @(negedge clk);
        isFloat = f; isExponentOdd = o; fraction = fr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; isFloat = ~f; isExponentOdd = ~o; fraction = ~fr;
        lat = 1;
        chk("busy_after_start", busy, 1);
        chk("root_cleared", root, 0);
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 1);
        r_out = root;
        x_out = isExact;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("root_hold", root, r_out);
    endtask

    initial begin
        vec_t        vt [9];
        logic [52:0] r;
        logic        x;
        logic [52:0] mq;
        logic        mx;
        logic [63:0] rnd;
        logic        f;
        logic        o;
        int          lat;
        int          exp_lat;
        int          ndone;
        int          first_done;
        int          seen;

        vt[0] = '{1'b0, 1'b0, 52'h0,             53'h10000000000000, 1'b1, 54, 2};
        vt[1] = '{1'b0, 1'b1, 52'h0,             53'h16A09E667F3BCC, 1'b0, 54, 54};
        vt[2] = '{1'b1, 1'b1, 52'h100000,        53'h0000000C00000,  1'b1, 25, 3};
        vt[3] = '{1'b1, 1'b1, 52'hFFFFFFF900000, 53'h0000000C00000,  1'b1, 25, 3};
        vt[4] = '{1'b1, 1'b0, 52'h0,             53'h0000000800000,  1'b1, 25, 2};
        vt[5] = '{1'b0, 1'b1, 52'h2000000000000, 53'h18000000000000, 1'b1, 54, 3};
        vt[6] = '{1'b0, 1'b0, 52'h9000000000000, 53'h14000000000000, 1'b1, 54, 4};
        vt[7] = '{1'b1, 1'b0, 52'h480000,        53'h0000000A00000,  1'b1, 25, 4};
        vt[8] = '{1'b1, 1'b1, 52'h0,             53'h0000000B504F3,  1'b0, 25, 25};

        rstN = 1'b0; start = 1'b0; isFloat = 1'b0; isExponentOdd = 1'b0; fraction = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_root", root, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_exact", isExact, 0);
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_job(vt[i].isf, vt[i].odd, vt[i].frac, r, x, lat);
`ifdef SQRT_EARLY_EXIT_EN
            exp_lat = vt[i].lat_ee;
`else
            exp_lat = vt[i].lat;
`endif
            chk($sformatf("vec%0d_root", i), r, vt[i].exp_root);
            chk($sformatf("vec%0d_exact", i), x, vt[i].exp_exact);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat);
        end

        // Start held high: one result, re-acceptance only after the idle cycle.
        ndone = 0; first_done = 0; r = '0; x = 1'b0;
        @(negedge clk);
        isFloat = 1'b1; isExponentOdd = 1'b0; fraction = '0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            #1;
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = c; r = root; x = isExact;
                end
            end
            if (first_done != 0 && c == first_done + 1) chk("hold_idle_after_done", busy, 0);
            if (first_done != 0 && c == first_done + 2) chk("hold_reaccept", busy, 1);
            if (c < 30) @(posedge clk);
        end
        start = 1'b0;
        chk("hold_root", r, 53'h800000);
        chk("hold_exact", x, 1);
`ifdef SQRT_EARLY_EXIT_EN
        chk("hold_first_done_cycle", first_done, 2);
        chk("hold_done_count", ndone, 10);
        @(posedge clk); #1;
        chk("hold_final_idle", busy, 0);
`else
        chk("hold_first_done_cycle", first_done, 25);
        chk("hold_done_count", ndone, 1);
        lat = 30;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_second_done_cycle", lat, 51);
        chk("hold_second_root", root, 53'h800000);
        @(posedge clk); #1;
`endif

        // Asynchronous abort in the middle of a double job.
        @(negedge clk);
        isFloat = 1'b0; isExponentOdd = 1'b1; fraction = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_root", root, 0);
        chk("abort_exact", isExact, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_stays_idle", seen, 0);
        run_job(1'b0, 1'b1, 52'h0, r, x, lat);
        chk("post_abort_root", r, 53'h16A09E667F3BCC);
        chk("post_abort_exact", x, 0);
        chk("post_abort_latency", lat, 54);

        // Random vectors against the trial-squaring model.
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom, $urandom};
            f   = i[0];
            o   = 1'($urandom_range(0, 1));
            ref_sqrt(f, o, rnd[51:0], mq, mx);
            run_job(f, o, rnd[51:0], r, x, lat);
            chk("rand_root", r, mq);
            chk("rand_exact", x, mx);
`ifdef SQRT_EARLY_EXIT_EN
            chk("rand_latency_bound", (lat <= (f ? 25 : 54)), 1);
`else
            chk("rand_latency", lat, f ? 25 : 54);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
